// File: rtl/mem_arb_pkg.sv
// Shared constants and helpers for the CPU/DMA RAM arbiter.
// Also used by the optional wait counters (MEM_ARB_PERF_CNT_EN).
package mem_arb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_ACK   = 2'd3;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  localparam int PERF_W = 16;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_ISSUE = ST_ISSUE,
    S_WAIT  = ST_WAIT,
    S_ACK   = ST_ACK
  } state_e;

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of CPU, DMA and RAM-side signals around the arbiter.
// Wait-counter outputs exist only when MEM_ARB_PERF_CNT_EN is defined.
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;
  logic              cpu_stall;

  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic [DATA_W-1:0] dma_rdata;
  logic              dma_ack;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;
  logic              grant_id;

`ifdef MEM_ARB_PERF_CNT_EN
  logic [PERF_W-1:0] cpu_wait_cnt;
  logic [PERF_W-1:0] dma_wait_cnt;
`endif

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  mem_rdata,
    output cpu_rdata, cpu_ack, cpu_stall,
    output dma_rdata, dma_ack,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output busy, grant_id
`ifdef MEM_ARB_PERF_CNT_EN
    , output cpu_wait_cnt, dma_wait_cnt
`endif
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output mem_rdata,
    input  cpu_rdata, cpu_ack, cpu_stall,
    input  dma_rdata, dma_ack,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  busy, grant_id
`ifdef MEM_ARB_PERF_CNT_EN
    , input cpu_wait_cnt, dma_wait_cnt
`endif
  );

endinterface

// File: rtl/mem_arb_rr.sv
// Combinational 2-way round-robin picker: on a tie the port that did not
// win last time is chosen. req[0] is the CPU, req[1] the DMA port.
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_valid,
  output logic       gnt_id
);

  always_comb begin
    gnt_valid = |req;
    gnt_id    = PORT_CPU;
    unique case (req)
      2'b01:   gnt_id = PORT_CPU;
      2'b10:   gnt_id = PORT_DMA;
      2'b11:   gnt_id = ~last_grant;
      default: gnt_id = PORT_CPU;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between the CPU memory path and a DMA/loader port.
// Optional per-port wait counters are enabled with MEM_ARB_PERF_CNT_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic         Clock,
  input  logic         Reset,
  mem_arbiter_if.slave bus
);

  localparam int         CNT_W     = 3;
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(RD_LAT - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              latch_req;
  logic              cap_rdata;

  logic              last_grant_q;
  logic              win_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] dma_rdata_q;

  logic              gnt_valid;
  logic              gnt_id;

  mem_arb_rr u_rr (
    .req        ({bus.dma_req, bus.cpu_req}),
    .last_grant (last_grant_q),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    latch_req = 1'b0;
    cap_rdata = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (gnt_valid) begin
          latch_req = 1'b1;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (we_q) begin
          state_d = S_ACK;
        end else begin
          cnt_d   = WAIT_INIT;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // Counter hits zero on the last of RD_LAT wait cycles, when RAM data is valid.
        if (cnt_q == '0) begin
          cap_rdata = 1'b1;
          state_d   = S_ACK;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      last_grant_q <= PORT_DMA;
      win_q        <= PORT_CPU;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cpu_rdata_q  <= '0;
      dma_rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (latch_req) begin
        win_q        <= gnt_id;
        last_grant_q <= gnt_id;
        we_q         <= (gnt_id == PORT_DMA) ? bus.dma_we    : bus.cpu_we;
        addr_q       <= (gnt_id == PORT_DMA) ? bus.dma_addr  : bus.cpu_addr;
        wdata_q      <= (gnt_id == PORT_DMA) ? bus.dma_wdata : bus.cpu_wdata;
      end
      if (cap_rdata) begin
        if (win_q == PORT_DMA) dma_rdata_q <= bus.mem_rdata;
        else                   cpu_rdata_q <= bus.mem_rdata;
      end
    end
  end

  assign bus.mem_en    = (state_q == S_ISSUE);
  assign bus.mem_we    = (state_q == S_ISSUE) && we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

  assign bus.cpu_ack   = (state_q == S_ACK) && (win_q == PORT_CPU);
  assign bus.dma_ack   = (state_q == S_ACK) && (win_q == PORT_DMA);
  assign bus.cpu_stall = bus.cpu_req & ~bus.cpu_ack;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.dma_rdata = dma_rdata_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.grant_id  = last_grant_q;

`ifdef MEM_ARB_PERF_CNT_EN
  logic [PERF_W-1:0] cpu_wait_q;
  logic [PERF_W-1:0] dma_wait_q;
  logic              cpu_active;
  logic              dma_active;

  // A port is "served" from its ISSUE cycle through its ACK cycle.
  assign cpu_active = (state_q != S_IDLE) && (win_q == PORT_CPU);
  assign dma_active = (state_q != S_IDLE) && (win_q == PORT_DMA);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      cpu_wait_q <= '0;
      dma_wait_q <= '0;
    end else begin
      if (bus.cpu_req && !cpu_active) cpu_wait_q <= sat_inc(cpu_wait_q);
      if (bus.dma_req && !dma_active) dma_wait_q <= sat_inc(dma_wait_q);
    end
  end

  assign bus.cpu_wait_cnt = cpu_wait_q;
  assign bus.dma_wait_cnt = dma_wait_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: two DUTs (RD_LAT=1 and RD_LAT=3), each with
// a behavioural RAM; drivers push expected acks/RAM accesses, monitors pop and compare.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 9;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst [2];

  // Channel index i = 2*dut + port (port 0 = CPU, 1 = DMA)
  logic          req_s   [4];
  logic          we_s    [4];
  logic [AW-1:0] addr_s  [4];
  logic [DW-1:0] wdata_s [4];
  logic          ack_s   [4];
  logic          stall_s [4];
  logic [DW-1:0] rdata_s [4];

  logic          mem_en_s    [2];
  logic          mem_we_s    [2];
  logic [AW-1:0] mem_addr_s  [2];
  logic [DW-1:0] mem_wdata_s [2];
  logic          busy_s      [2];
  logic          gid_s       [2];

  for (genvar g = 0; g < 2; g++) begin : g_d
    localparam int LAT = (g == 0) ? 1 : 3;
    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) u_dut (
      .Clock (clk),
      .Reset (rst[g]),
      .bus   (bus)
    );

    assign bus.cpu_req   = req_s[2*g];
    assign bus.cpu_we    = we_s[2*g];
    assign bus.cpu_addr  = addr_s[2*g];
    assign bus.cpu_wdata = wdata_s[2*g];
    assign bus.dma_req   = req_s[2*g+1];
    assign bus.dma_we    = we_s[2*g+1];
    assign bus.dma_addr  = addr_s[2*g+1];
    assign bus.dma_wdata = wdata_s[2*g+1];

    assign ack_s[2*g]     = bus.cpu_ack;
    assign ack_s[2*g+1]   = bus.dma_ack;
    assign stall_s[2*g]   = bus.cpu_stall;
    assign stall_s[2*g+1] = 1'b0;
    assign rdata_s[2*g]   = bus.cpu_rdata;
    assign rdata_s[2*g+1] = bus.dma_rdata;
    assign mem_en_s[g]    = bus.mem_en;
    assign mem_we_s[g]    = bus.mem_we;
    assign mem_addr_s[g]  = bus.mem_addr;
    assign mem_wdata_s[g] = bus.mem_wdata;
    assign busy_s[g]      = bus.busy;
    assign gid_s[g]       = bus.grant_id;

    // RAM model: read data valid exactly LAT cycles after the issue cycle, poison otherwise
    logic [DW-1:0] ram  [512];
    logic [DW-1:0] pipe [LAT];
    logic          pv   [LAT];
    initial for (int k = 0; k < LAT; k++) pv[k] = 1'b0;
    always @(posedge clk) begin
      if (bus.mem_en && bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      pipe[0] <= ram[bus.mem_addr];
      pv[0]   <= bus.mem_en && !bus.mem_we;
      for (int k = 1; k < LAT; k++) begin
        pipe[k] <= pipe[k-1];
        pv[k]   <= pv[k-1];
      end
    end
    assign bus.mem_rdata = pv[LAT-1] ? pipe[LAT-1] : 32'hBAD0_BAD0;
  end

  typedef struct {
    bit            rd;
    logic [DW-1:0] data;
    int            lat;
  } ack_exp_t;

  typedef struct {
    logic [AW-1:0] addr;
    bit            we;
    logic [DW-1:0] wdata;
    bit            gid;
  } mem_exp_t;

  ack_exp_t      ack_q [4][$];
  mem_exp_t      mem_q [2][$];
  int            req_cyc [4];
  logic [DW-1:0] rd_model [4];
  logic          prev_en [2];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_mem(input int d, input logic [AW-1:0] a, input bit we,
                          input logic [DW-1:0] wd, input bit gid);
    mem_exp_t m;
    m.addr = a; m.we = we; m.wdata = wd; m.gid = gid;
    mem_q[d].push_back(m);
  endtask

  // Issue one transaction on channel i and hold req until its ack.
  task automatic xact(input int i, input bit we, input logic [AW-1:0] addr,
                      input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rd, input int lat);
    ack_exp_t e;
    bit got;
    e.rd = !we; e.data = exp_rd; e.lat = lat;
    ack_q[i].push_back(e);
    we_s[i] = we; addr_s[i] = addr; wdata_s[i] = wdata;
    req_s[i] = 1'b1;
    req_cyc[i] = cyc;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (ack_s[i] === 1'b1) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout ch%0d: no ack within 40 cycles, expected one", i);
    end
    @(posedge clk); #1;
    req_s[i] = 1'b0;
  endtask

  // Ack and RAM-side monitor
  always @(negedge clk) begin
    ack_exp_t e;
    mem_exp_t m;
    for (int i = 0; i < 4; i++) begin
      if (ack_s[i] === 1'b1) begin
        if (ack_q[i].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack ch%0d: ack=1, expected 0", i);
        end else begin
          e = ack_q[i].pop_front();
          if (e.lat >= 0) chk($sformatf("ack_latency ch%0d", i), 64'(cyc - req_cyc[i]), 64'(e.lat));
          if (e.rd) begin
            chk($sformatf("rdata ch%0d", i), rdata_s[i], e.data);
            rd_model[i] = e.data;
          end else begin
            chk($sformatf("rdata_hold_on_write ch%0d", i), rdata_s[i], rd_model[i]);
          end
          chk($sformatf("other_rdata ch%0d", i ^ 1), rdata_s[i ^ 1], rd_model[i ^ 1]);
          if (i % 2 == 0) chk($sformatf("stall_at_ack ch%0d", i), stall_s[i], 0);
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      if (mem_we_s[d] === 1'b1 && mem_en_s[d] !== 1'b1) begin
        checks++;
        errors++;
        $display("FAIL mem_we_unqualified dut%0d: mem_we=1 with mem_en=%0b, expected 0", d, mem_en_s[d]);
      end
      if (mem_en_s[d] === 1'b1) begin
        if (prev_en[d] === 1'b1) begin
          checks++;
          errors++;
          $display("FAIL mem_en_width dut%0d: mem_en high 2 cycles, expected 1", d);
        end
        if (mem_q[d].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_mem_en dut%0d: addr %0h, expected none", d, mem_addr_s[d]);
        end else begin
          m = mem_q[d].pop_front();
          chk($sformatf("mem_addr dut%0d", d), mem_addr_s[d], m.addr);
          chk($sformatf("mem_we dut%0d", d), mem_we_s[d], m.we);
          chk($sformatf("grant_id dut%0d", d), gid_s[d], m.gid);
          if (m.we) chk($sformatf("mem_wdata dut%0d", d), mem_wdata_s[d], m.wdata);
        end
      end
      prev_en[d] = mem_en_s[d];
    end
  end

  task automatic reset_dut(input int d);
    rst[d] = 1'b1;
    @(posedge clk); #1;
    rst[d] = 1'b0;
    rd_model[2*d] = '0;
    rd_model[2*d+1] = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      req_s[i] = 1'b0; we_s[i] = 1'b0; addr_s[i] = '0; wdata_s[i] = '0;
      rd_model[i] = '0; req_cyc[i] = 0;
    end
    prev_en[0] = 1'b0; prev_en[1] = 1'b0;
    rst[0] = 1'b1; rst[1] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst[0] = 1'b0; rst[1] = 1'b0;

    // Reset state
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_busy dut%0d", d), busy_s[d], 0);
      chk($sformatf("rst_grant_id dut%0d", d), gid_s[d], 1);
      chk($sformatf("rst_mem_en dut%0d", d), mem_en_s[d], 0);
      chk($sformatf("rst_mem_addr dut%0d", d), mem_addr_s[d], 0);
      chk($sformatf("rst_mem_wdata dut%0d", d), mem_wdata_s[d], 0);
    end
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_rdata ch%0d", i), rdata_s[i], 0);
      chk($sformatf("rst_ack ch%0d", i), ack_s[i], 0);
    end
    @(posedge clk); #1;

    // CPU write then read, RD_LAT=1
    push_mem(0, 9'h010, 1'b1, 32'hDEADBEEF, PORT_CPU);
    xact(0, 1'b1, 9'h010, 32'hDEADBEEF, '0, 2);
    push_mem(0, 9'h010, 1'b0, '0, PORT_CPU);
    fork
      xact(0, 1'b0, 9'h010, 32'h0, 32'hDEADBEEF, 3);
      begin
        @(negedge clk);
        chk("cpu_stall_pending", stall_s[0], 1);
        @(negedge clk);
        chk("busy_during_issue", busy_s[0], 1);
      end
    join

    // Tie right after reset: CPU first, then DMA
    reset_dut(0);
    push_mem(0, 9'h001, 1'b1, 32'h1111_1111, PORT_CPU);
    push_mem(0, 9'h002, 1'b1, 32'h2222_2222, PORT_DMA);
    fork
      xact(0, 1'b1, 9'h001, 32'h1111_1111, '0, 2);
      xact(1, 1'b1, 9'h002, 32'h2222_2222, '0, 5);
    join

    // Fairness: both ports hold req for 6 back-to-back writes
    for (int j = 0; j < 3; j++) begin
      push_mem(0, AW'(9'h020 + j), 1'b1, 32'hC000_0000 + j, PORT_CPU);
      push_mem(0, AW'(9'h030 + j), 1'b1, 32'hD000_0000 + j, PORT_DMA);
    end
    fork
      for (int j = 0; j < 3; j++) xact(0, 1'b1, AW'(9'h020 + j), 32'hC000_0000 + j, '0, -1);
      for (int j = 0; j < 3; j++) xact(1, 1'b1, AW'(9'h030 + j), 32'hD000_0000 + j, '0, -1);
    join
    push_mem(0, 9'h031, 1'b0, '0, PORT_DMA);
    xact(1, 1'b0, 9'h031, '0, 32'hD000_0001, 3);

    // Latency sweep on the RD_LAT=3 instance
    push_mem(1, 9'h055, 1'b1, 32'hCAFE_F00D, PORT_DMA);
    xact(3, 1'b1, 9'h055, 32'hCAFE_F00D, '0, 2);
    push_mem(1, 9'h055, 1'b0, '0, PORT_DMA);
    fork
      xact(3, 1'b0, 9'h055, '0, 32'hCAFE_F00D, 5);
      begin
        @(negedge clk);
        chk("lat3_mem_en_c0", mem_en_s[1], 0);
        @(negedge clk);
        chk("lat3_mem_en_c1", mem_en_s[1], 1);
      end
    join

    // Reset during WAIT aborts the read with no ack
    push_mem(0, 9'h010, 1'b0, '0, PORT_CPU);
    we_s[0] = 1'b0; addr_s[0] = 9'h010; req_s[0] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst[0] = 1'b1;
    req_s[0] = 1'b0;
    @(posedge clk); #1;
    rst[0] = 1'b0;
    rd_model[0] = '0; rd_model[1] = '0;
    @(negedge clk);
    chk("abort_busy", busy_s[0], 0);
    chk("abort_mem_en", mem_en_s[0], 0);
    chk("abort_cpu_ack", ack_s[0], 0);
    chk("abort_cpu_rdata", rdata_s[0], 0);
    chk("abort_dma_rdata", rdata_s[1], 0);
    chk("abort_grant_id", gid_s[0], 1);
    @(posedge clk); #1;
    push_mem(0, 9'h010, 1'b0, '0, PORT_CPU);
    xact(0, 1'b0, 9'h010, '0, 32'hDEADBEEF, 3);

`ifdef MEM_ARB_PERF_CNT_EN
    reset_dut(0);
    @(negedge clk);
    chk("perf_rst_cpu", g_d[0].bus.cpu_wait_cnt, 0);
    chk("perf_rst_dma", g_d[0].bus.dma_wait_cnt, 0);
    @(posedge clk); #1;
    push_mem(0, 9'h010, 1'b0, '0, PORT_CPU);
    push_mem(0, 9'h040, 1'b1, 32'h55AA_55AA, PORT_DMA);
    fork
      xact(0, 1'b0, 9'h010, '0, 32'hDEADBEEF, 3);
      begin
        @(posedge clk); #1;
        xact(1, 1'b1, 9'h040, 32'h55AA_55AA, '0, -1);
      end
      begin
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
          @(negedge clk);
          if (mem_en_s[0] === 1'b1 && gid_s[0] === 1'b1) seen = 1'b1;
        end
        chk("perf_dma_issue_seen", seen, 1);
        chk("perf_dma_wait_cnt", g_d[0].bus.dma_wait_cnt, 4);
        chk("perf_cpu_wait_cnt", g_d[0].bus.cpu_wait_cnt, 1);
      end
    join
    force g_d[0].u_dut.dma_wait_q = 16'hFFFC;
    #1;
    release g_d[0].u_dut.dma_wait_q;
    @(posedge clk); #1;
    push_mem(0, 9'h010, 1'b0, '0, PORT_CPU);
    push_mem(0, 9'h041, 1'b1, 32'h0000_0041, PORT_DMA);
    fork
      xact(0, 1'b0, 9'h010, '0, 32'hDEADBEEF, 3);
      xact(1, 1'b1, 9'h041, 32'h0000_0041, '0, -1);
    join
    @(negedge clk);
    chk("perf_dma_saturate", g_d[0].bus.dma_wait_cnt, 16'hFFFF);
`endif

    repeat (5) @(posedge clk);
    for (int i = 0; i < 4; i++) chk($sformatf("ack_queue_drained ch%0d", i), ack_q[i].size(), 0);
    for (int d = 0; d < 2; d++) chk($sformatf("mem_queue_drained dut%0d", d), mem_q[d].size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
